nmea_uart_rx: RTL and testbench

- UART receiver, 8N1, directly upstream of the NMEA parser; converts the GPS module's asynchronous serial line into a byte stream.
- Output is a one-byte-per-pulse interface: dataByte is qualified by a single-cycle dataReady. The parser requires dataReady high for exactly one sclk cycle per byte.
- Uses 16x oversampling, majority-vote bit sampling, false-start rejection and framing-error detection.

---
 rtl/nmea_uart_rx.sv | 177 +++++++++++++++++
 tb/tb_nmea_uart_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/nmea_uart_rx.sv
// rtl/nmea_uart_rx.sv - 8N1 UART receiver, 16x oversampled with majority voting, feeding the NMEA parser.
// Emits one single-cycle dataReady per good byte; framing errors pulse frameErr and bump a saturating count.
module nmea_uart_rx #(
    parameter int SYSCLK_FREQ = 100_000_000,
    parameter int BAUD        = 9600
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dataByte,
    output logic       dataReady,
    output logic       frameErr,
    output logic [7:0] frameErrCnt,
    output logic       busy
);

    localparam int DIV   = (SYSCLK_FREQ + 8 * BAUD) / (16 * BAUD);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic             rx_meta_q;
    logic             rxs_q;
    logic             rxs_prev_q, rxs_prev_d;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       samp_q, samp_d;
    logic [7:0]       data_byte_q, data_byte_d;
    logic             data_ready_q, data_ready_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             busy_q, busy_d;

    logic tick;
    logic vote;
    logic sample_end;
    logic wrap;

    assign tick       = (div_q == DIV_MAX);
    assign sample_end = tick && (tick_cnt_q == 4'd9);
    assign wrap       = tick && (tick_cnt_q == 4'd15);
    // Third vote is the live sample taken on tick 9 itself.
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);

    always_comb begin
        state_d      = state_q;
        rxs_prev_d   = rxs_q;
        div_d        = tick ? '0 : div_q + 1'b1;
        tick_cnt_d   = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        samp_d       = samp_q;
        data_byte_d  = data_byte_q;
        data_ready_d = 1'b0;
        frame_err_d  = 1'b0;
        err_cnt_d    = err_cnt_q;

        if (tick && (tick_cnt_q == 4'd7)) begin
            samp_d[0] = rxs_q;
        end
        if (tick && (tick_cnt_q == 4'd8)) begin
            samp_d[1] = rxs_q;
        end

        case (state_q)
            S_IDLE: begin
                // Restart the divider on the edge so ticks are phase-locked to the frame.
                if (rxs_prev_q && !rxs_q) begin
                    state_d    = S_START;
                    div_d      = '0;
                    tick_cnt_d = 4'd0;
                end
            end
            S_START: begin
                if (sample_end && vote) begin
                    state_d = S_IDLE;
                end else if (wrap) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (sample_end) begin
                    shift_d[bit_idx_q] = vote;
                end
                if (wrap) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // Leave mid stop bit so a back-to-back start edge is not missed.
                if (sample_end) begin
                    if (vote) begin
                        data_byte_d  = shift_q;
                        data_ready_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        tick_cnt_d = 4'd0;
                        state_d    = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // tick_cnt doubles as the count of consecutive high ticks.
                if (!rxs_q) begin
                    tick_cnt_d = 4'd0;
                end else if (wrap) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            state_q      <= S_IDLE;
            div_q        <= '0;
            tick_cnt_q   <= 4'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
            samp_q       <= 2'b11;
            data_byte_q  <= 8'd0;
            data_ready_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_cnt_q    <= 8'd0;
            busy_q       <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rxs_q        <= rx_meta_q;
            rxs_prev_q   <= rxs_prev_d;
            state_q      <= state_d;
            div_q        <= div_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            samp_q       <= samp_d;
            data_byte_q  <= data_byte_d;
            data_ready_q <= data_ready_d;
            frame_err_q  <= frame_err_d;
            err_cnt_q    <= err_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign dataByte    = data_byte_q;
    assign dataReady   = data_ready_q;
    assign frameErr    = frame_err_q;
    assign frameErrCnt = err_cnt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_nmea_uart_rx.sv
// tb/tb_nmea_uart_rx.sv - directed bench for nmea_uart_rx with an expected-byte scoreboard.
module tb_nmea_uart_rx;

    localparam int SYSCLK_FREQ = 1_843_200;
    localparam int BAUD        = 115_200;
    localparam int DIV         = (SYSCLK_FREQ + 8 * BAUD) / (16 * BAUD);
    localparam int CLK         = 1000;
    localparam int BIT_CYC     = 16 * DIV;
    localparam int BIT         = BIT_CYC * CLK;
    localparam int FAST_BIT    = BIT * 100 / 102;

    logic       sclk;
    logic       rst;
    logic       rx;
    logic [7:0] dataByte;
    logic       dataReady;
    logic       frameErr;
    logic [7:0] frameErrCnt;
    logic       busy;

    nmea_uart_rx #(
        .SYSCLK_FREQ(SYSCLK_FREQ),
        .BAUD       (BAUD)
    ) dut (
        .sclk       (sclk),
        .rst        (rst),
        .rx         (rx),
        .dataByte   (dataByte),
        .dataReady  (dataReady),
        .frameErr   (frameErr),
        .frameErrCnt(frameErrCnt),
        .busy       (busy)
    );

    initial sclk = 1'b0;
    always #(CLK / 2) sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc++;

    logic [7:0] got [0:63];
    int         rdy_cyc [0:63];
    int         rdy_count  = 0;
    int         ferr_count = 0;
    int         wide_viol  = 0;
    int         both_viol  = 0;
    logic       prev_rdy   = 1'b0;
    logic       prev_ferr  = 1'b0;

    always @(negedge sclk) begin
        if (dataReady === 1'b1) begin
            if (rdy_count < 64) begin
                got[rdy_count]     = dataByte;
                rdy_cyc[rdy_count] = cyc;
            end
            rdy_count++;
            if (prev_rdy) wide_viol++;
            if (frameErr === 1'b1) both_viol++;
        end
        if (frameErr === 1'b1) begin
            ferr_count++;
            if (prev_ferr) wide_viol++;
        end
        prev_rdy  = (dataReady === 1'b1);
        prev_ferr = (frameErr === 1'b1);
    end

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q [$];
    int         pushed = 0;
    int         rd_idx = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic push(input logic [7:0] b);
        exp_q.push_back(b);
        pushed++;
    endtask

    task automatic send_frame(input logic [7:0] b, input int bit_t, input logic stop_v);
        rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_t);
        end
        rx = stop_v;
        #(bit_t);
    endtask

    task automatic drain(input string tag);
        logic [7:0] e;
        for (int i = 0; i < 4 * BIT_CYC && rdy_count < pushed; i++) @(negedge sclk);
        chk({tag, "_count"}, rdy_count, pushed);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_byte"}, (rd_idx < 64) ? got[rd_idx] : 8'hxx, e);
            rd_idx++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dataByte"}, dataByte, 8'h00);
        chk({tag, "_dataReady"}, dataReady, 1'b0);
        chk({tag, "_frameErr"}, frameErr, 1'b0);
        chk({tag, "_frameErrCnt"}, frameErrCnt, 8'h00);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        string      nmea;
        int         start_cyc;
        int         base;
        logic [7:0] b3c;

        nmea = "$GPGGA,123519.000,4807.0380,N*hh\r\n";
        rst  = 1'b1;
        rx   = 1'b1;
        repeat (5) @(negedge sclk);
        rst = 1'b0;
        @(negedge sclk);
        chk_reset_outputs("reset");

        // Back-to-back '$' 'G' at nominal rate.
        start_cyc = cyc;
        push(8'h24);
        send_frame(8'h24, BIT, 1'b1);
        push(8'h47);
        send_frame(8'h47, BIT, 1'b1);
        rx = 1'b1;
        drain("b2b");
        chk_range("b2b_latency", rdy_cyc[0] - start_cyc, 153 * DIV + 2 - DIV, 153 * DIV + 2 + DIV + 3);
        chk_range("b2b_spacing", rdy_cyc[1] - rdy_cyc[0], 10 * BIT_CYC - DIV, 10 * BIT_CYC + DIV);
        chk("b2b_frameErr", ferr_count, 0);

        // Whole sentence 2% fast, no idle between characters.
        for (int i = 0; i < nmea.len(); i++) begin
            push(nmea[i]);
            send_frame(nmea[i], FAST_BIT, 1'b1);
        end
        rx = 1'b1;
        drain("nmea");
        chk("nmea_frameErr", ferr_count, 0);

        // Short glitch while idle.
        repeat (BIT_CYC) @(negedge sclk);
        base = rdy_count;
        rx   = 1'b0;
        repeat (4) @(negedge sclk);
        chk("glitch_busy_high", busy, 1'b1);
        rx = 1'b1;
        repeat (BIT_CYC - 4) @(negedge sclk);
        chk("glitch_busy_low", busy, 1'b0);
        repeat (2 * BIT_CYC) @(negedge sclk);
        chk("glitch_no_ready", rdy_count, base);

        // 0x55 with low stop bit, 2-bit break, then 0xA5.
        send_frame(8'h55, BIT, 1'b0);
        rx = 1'b0;
        #(2 * BIT);
        rx = 1'b1;
        #(3 * BIT);
        chk("ferr_pulses", ferr_count, 1);
        chk("ferr_cnt", frameErrCnt, 8'd1);
        chk("ferr_byte_kept", dataByte, 8'h0A);
        chk("ferr_no_ready", rdy_count, base);
        push(8'hA5);
        send_frame(8'hA5, BIT, 1'b1);
        rx = 1'b1;
        drain("after_ferr");

        // Reset in the middle of bit 4 of 0x3C; the line then goes idle.
        repeat (BIT_CYC) @(negedge sclk);
        base = rdy_count;
        b3c  = 8'h3C;
        rx   = 1'b0;
        #(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = b3c[i];
            #(BIT);
        end
        rx = b3c[4];
        #(BIT / 2);
        @(negedge sclk);
        rst = 1'b1;
        @(negedge sclk);
        rst = 1'b0;
        rx  = 1'b1;
        chk_reset_outputs("midreset");
        repeat (12 * BIT_CYC) @(negedge sclk);
        chk("midreset_no_ready", rdy_count, base);
        chk("midreset_no_ferr", ferr_count, 1);
        push(8'h0D);
        send_frame(8'h0D, BIT, 1'b1);
        rx = 1'b1;
        drain("after_reset");
        chk("after_reset_dataByte", dataByte, 8'h0D);

        // 256 framing errors: counter must stop at 255.
        for (int i = 0; i < 256; i++) begin
            send_frame(8'h00, BIT, 1'b0);
            rx = 1'b1;
            repeat (BIT_CYC + 8) @(negedge sclk);
            if (i == 0) chk("sat_cnt_1", frameErrCnt, 8'd1);
            if (i == 254) chk("sat_cnt_255", frameErrCnt, 8'd255);
        end
        chk("sat_cnt_256", frameErrCnt, 8'd255);
        chk("sat_pulses", ferr_count, 257);
        chk("sat_byte_kept", dataByte, 8'h0D);
        chk("sat_no_ready", rdy_count, pushed);
        chk("pulse_width", wide_viol, 0);
        chk("ready_and_ferr", both_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
